host_rf_access_ctrl: RTL and testbench
======================================

Name: host_rf_access_ctrl

Overview:
- Chip-side sequencer for the serial host port, placed between the serial loader (addr_reg/din_reg/dout_for_chip) and the ComputeCore3 register files.
- Decodes the LAD2/LAD1 phase pins and counts the bits shifted in.
- Commits complete write frames to the register file as single-cycle write strobes.
- For read-out, fetches the addressed word, holds it stable for the serial stream-out, and stalls the compute core while the host owns the register file.

Parameters:
- ADDR_W, 10, address width; equals the width of addr_reg.
- DATA_W, 64, register-file word width; equals the width of din_reg.
- RD_LAT, 1, register-file read latency in cycles; legal values are 0 and 1.
- STREAM_LEN, 67, cycles per serial read-out frame; equals DATA_W+3.

Ports:
- clk1  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- LAD1  in  1  phase pin, low bit.
- LAD2  in  1  phase pin, high bit.
- addr_reg  in  ADDR_W  address shifted in by the serial loader.
- din_reg  in  DATA_W  data shifted in by the serial loader.
- rf_rdata  in  DATA_W  register-file read data, valid RD_LAT cycles after rf_re.
- rf_we  out  1  register-file write strobe, one cycle wide.
- rf_re  out  1  register-file read strobe, one cycle wide.
- rf_addr  out  ADDR_W  register-file address.
- rf_wdata  out  DATA_W  register-file write data.
- data_from_RF_to_chip_output  out  DATA_W  read word held for serial stream-out.
- core_hold  out  1  stalls ComputeCore3 while the host owns the register file.
- stream_done  out  1  one-cycle pulse at the end of each read-out frame.
- err_frame  out  1  sticky frame-error flag; cleared only by rst.

Behaviour:
- Phase encoding {LAD2,LAD1}: 00 = NOP, 01 = address shift, 10 = data shift, 11 = read-out.
- Reset (synchronous, rst=1 at a clk1 edge):
  - All outputs go to 0: strobes, address, write data, hold word, flags.
  - Internal counters and state clear; the FSM goes to IDLE.
  - Reset mid-frame abandons the frame: no strobe is issued afterwards.
- Counters:
  - addr_cnt (0..ADDR_W) increments once per cycle in phase 01 and saturates at ADDR_W.
  - data_cnt (0..DATA_W) increments once per cycle in phase 10 and saturates at DATA_W.
  - Moving directly between 01 and 10 keeps both counters.
- FSM states: IDLE, SHIFT, COMMIT, RD_ISSUE, RD_WAIT, STREAM.
- IDLE: phase 01 or 10 -> SHIFT; phase 11 -> RD_ISSUE.
- SHIFT: phase returns to 00:
  - data_cnt==DATA_W and addr_cnt==ADDR_W -> COMMIT.
  - data_cnt==0 -> IDLE, no error (address-only preload).
  - any other case -> set err_frame, clear counters, -> IDLE.
- SHIFT: phase 11 -> RD_ISSUE. Counters are kept, so data bits shifted before the read are not lost.
- COMMIT (one cycle):
  - rf_we=1, rf_addr=addr_reg, rf_wdata=din_reg.
  - data_cnt clears and addr_cnt is kept, so back-to-back data frames write the same address.
  - Next state IDLE.
- RD_ISSUE:
  - addr_cnt==ADDR_W: rf_re=1 and rf_addr=addr_reg for exactly one cycle. Next state is RD_WAIT if RD_LAT==1, else STREAM.
  - addr_cnt<ADDR_W: set err_frame, clear the hold word to 0, no rf_re, go to STREAM (the frame streams zeros).
- RD_WAIT: capture rf_rdata into data_from_RF_to_chip_output; -> STREAM.
  - The hold word is therefore valid no later than the 2nd cycle after phase 11 is first seen, before the loader samples bit 0.
- STREAM:
  - stream_cnt counts 0..STREAM_LEN from phase-11 entry.
  - At stream_cnt==STREAM_LEN: pulse stream_done and wrap to 0.
  - Phase still 11: stay in STREAM and start a new frame with the same hold word; no re-read.
  - Phase leaves 11 at any point: -> IDLE, stream_cnt clears, hold word retained.
- core_hold = (state != IDLE) OR (phase != 00), combinational.
- rf_we and rf_re are never high in the same cycle.
- The strobes are registered outputs. rf_addr and rf_wdata hold their last values when no strobe is active.

Decomposition:
- Package saber_io_pkg holds:
  - LAD phase encodings (LAD_NOP/LAD_ADDR/LAD_DATA/LAD_READ);
  - ADDR_W/DATA_W/STREAM_LEN defaults;
  - FSM state encoding.
- One sub-module, sat_bit_counter (parameterised width and max, with inc/clr inputs and a full output), instantiated twice for addr_cnt and data_cnt.
- stream_cnt stays inline in the top module.

Test Plan:
- Write frame: 10 cycles of phase 01 with addr_reg=0x155, then 64 cycles of 10 with din_reg=0xDEADBEEF_01234567, then 00 -> rf_we=1 for exactly 1 cycle with rf_addr=0x155 and rf_wdata=0xDEADBEEF01234567; err_frame stays 0.
- Short data: 10 cycles of 01, then 40 cycles of 10, then 00 -> no rf_we; err_frame=1 and stays set until rst.
- Read: full address 0x2A0, then phase 11 with rf_rdata=0xA5A5... (RD_LAT=1) -> rf_re on the 1st cycle; hold word=0xA5A5... by the 2nd cycle; stream_done on cycle 67 of phase 11.
- Read without address: phase 11 straight from reset -> no rf_re, err_frame=1, hold word=0, core_hold=1 throughout.
- Continuous read: phase 11 held for 140 cycles -> stream_done pulses at the 2 frame ends; rf_re only once.
- Mid-frame reset: rst=1 during data cycle 30 -> next cycle all outputs 0 and state IDLE; a later 00 phase produces no rf_we.

Source files
------------

// File: rtl/saber_io_pkg.sv
// saber_io_pkg: shared phase encodings, default widths and FSM states for the serial host port
package saber_io_pkg;
    localparam logic [1:0] LAD_NOP  = 2'b00;
    localparam logic [1:0] LAD_ADDR = 2'b01;
    localparam logic [1:0] LAD_DATA = 2'b10;
    localparam logic [1:0] LAD_READ = 2'b11;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_STREAM_LEN = DEF_DATA_W + 3;
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        COMMIT,
        RD_ISSUE,
        RD_WAIT,
        STREAM
    } state_t;
endpackage

// File: rtl/host_rf_access_ctrl_if.sv
// host_rf_access_ctrl_if: register-file bus (master = sequencer, slave = register file)
//   rf_we/rf_re  one-cycle write/read strobes
//   rf_addr      word address
//   rf_wdata     write data
//   rf_rdata     read data, valid RD_LAT cycles after rf_re
interface host_rf_access_ctrl_if
    import saber_io_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              rf_we;
    logic              rf_re;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    modport master (output rf_we, rf_re, rf_addr, rf_wdata, input rf_rdata);
    modport slave  (input rf_we, rf_re, rf_addr, rf_wdata, output rf_rdata);
endinterface

// File: rtl/sat_bit_counter.sv
// sat_bit_counter: shift-bit counter saturating at MAX
//   clk1, rst  clock and synchronous active-high reset
//   inc        count one bit this cycle
//   clr        clear to zero (wins over inc)
//   cnt        current count 0..MAX
//   full       cnt == MAX
module sat_bit_counter #(
    parameter int MAX = 10,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         full
);
    assign full = cnt == W'(MAX);

    always_ff @(posedge clk1) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !full)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/host_rf_access_ctrl.sv
// host_rf_access_ctrl: serial host port sequencer driving the ComputeCore3 register file
//   clk1, rst                    clock and synchronous active-high reset
//   LAD2, LAD1                   phase pins: 00 NOP, 01 address, 10 data, 11 read-out
//   addr_reg, din_reg            address and data from the serial loader
//   rf                           register-file bus (master side)
//   data_from_RF_to_chip_output  read word held for serial stream-out
//   core_hold                    stalls the core while the host owns the register file
//   stream_done                  one-cycle pulse at each read-out frame end
//   err_frame                    sticky frame error, cleared only by rst
module host_rf_access_ctrl
    import saber_io_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int STREAM_LEN = DEF_STREAM_LEN
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  LAD1,
    input  logic                  LAD2,
    input  logic [ADDR_W-1:0]     addr_reg,
    input  logic [DATA_W-1:0]     din_reg,
    host_rf_access_ctrl_if.master rf,
    output logic [DATA_W-1:0]     data_from_RF_to_chip_output,
    output logic                  core_hold,
    output logic                  stream_done,
    output logic                  err_frame
);
    localparam int AW = $clog2(ADDR_W + 1);
    localparam int DW = $clog2(DATA_W + 1);
    localparam int SW = $clog2(STREAM_LEN + 1);
    localparam logic [SW-1:0] S_LAST = SW'(STREAM_LEN - 1);

    logic [1:0]        phase;
    state_t            state, state_d;
    logic [AW-1:0]     addr_cnt;
    logic [DW-1:0]     data_cnt;
    logic              addr_full, data_full;
    logic [SW-1:0]     stream_cnt;
    logic [DATA_W-1:0] hold_q;
    logic              frame_bad, rd_go, rd_cnt;

    assign phase = {LAD2, LAD1};
    assign core_hold = (state != IDLE) || (phase != LAD_NOP);
    // RD_WAIT forwards the arriving word so the loader sees it before the register catches it
    assign data_from_RF_to_chip_output = (RD_LAT == 1 && state == RD_WAIT) ? rf.rf_rdata : hold_q;
    assign rd_go = (state_d == RD_ISSUE) && addr_full;
    assign rd_cnt = (phase == LAD_READ) && (state_d inside {RD_ISSUE, RD_WAIT, STREAM});

    sat_bit_counter #(.MAX(ADDR_W), .W(AW)) u_addr_cnt (
        .clk1 (clk1),
        .rst  (rst),
        .inc  (phase == LAD_ADDR),
        .clr  (frame_bad),
        .cnt  (addr_cnt),
        .full (addr_full)
    );

    sat_bit_counter #(.MAX(DATA_W), .W(DW)) u_data_cnt (
        .clk1 (clk1),
        .rst  (rst),
        .inc  (phase == LAD_DATA),
        .clr  (frame_bad || state == COMMIT),
        .cnt  (data_cnt),
        .full (data_full)
    );

    always_comb begin
        state_d   = state;
        frame_bad = 1'b0;
        unique case (state)
            IDLE:     state_d = phase == LAD_READ ? RD_ISSUE : phase != LAD_NOP ? SHIFT : IDLE;
            SHIFT: begin
                if (phase == LAD_READ)
                    state_d = RD_ISSUE;
                else if (phase == LAD_NOP) begin
                    state_d   = (data_full && addr_cnt == AW'(ADDR_W)) ? COMMIT : IDLE;
                    frame_bad = !(data_full && addr_cnt == AW'(ADDR_W)) && data_cnt != '0;
                end
            end
            COMMIT:   state_d = IDLE;
            RD_ISSUE: state_d = (addr_full && RD_LAT == 1) ? RD_WAIT : STREAM;
            RD_WAIT:  state_d = STREAM;
            STREAM:   state_d = phase == LAD_READ ? STREAM : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state       <= IDLE;
            rf.rf_we    <= 1'b0;
            rf.rf_re    <= 1'b0;
            rf.rf_addr  <= '0;
            rf.rf_wdata <= '0;
            hold_q      <= '0;
            err_frame   <= 1'b0;
            stream_cnt  <= '0;
            stream_done <= 1'b0;
        end else begin
            state    <= state_d;
            rf.rf_we <= state_d == COMMIT;
            rf.rf_re <= rd_go;
            if (state_d == COMMIT || rd_go)
                rf.rf_addr <= addr_reg;
            if (state_d == COMMIT)
                rf.rf_wdata <= din_reg;
            if (frame_bad || (state == RD_ISSUE && !addr_full))
                err_frame <= 1'b1;
            // a read without a full address streams zeros; RD_LAT 0 data is already valid here
            if (state == RD_ISSUE && (!addr_full || RD_LAT == 0))
                hold_q <= addr_full ? rf.rf_rdata : '0;
            if (state == RD_WAIT)
                hold_q <= rf.rf_rdata;
            stream_done <= rd_cnt && stream_cnt == S_LAST;
            stream_cnt  <= (!rd_cnt || stream_cnt == S_LAST) ? '0 : stream_cnt + SW'(1);
        end
    end
endmodule

// File: tb/tb_host_rf_access_ctrl.sv
// tb_host_rf_access_ctrl: directed self-checking bench for host_rf_access_ctrl
module tb_host_rf_access_ctrl;
    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        LAD1 = 1'b0;
    logic        LAD2 = 1'b0;
    logic [9:0]  addr_reg = '0;
    logic [63:0] din_reg = '0;
    logic [63:0] rd_word = '0;
    logic [63:0] hold_word;
    logic        core_hold, stream_done, err_frame;
    int checks = 0;
    int errors = 0;
    int we_cnt, re_cnt, done_cnt, hold_lo, first_done, last_done;
    logic [9:0]  we_addr;
    logic [63:0] we_data;

    host_rf_access_ctrl_if #(.ADDR_W(10), .DATA_W(64)) bif ();

    host_rf_access_ctrl dut (
        .clk1                        (clk1),
        .rst                         (rst),
        .LAD1                        (LAD1),
        .LAD2                        (LAD2),
        .addr_reg                    (addr_reg),
        .din_reg                     (din_reg),
        .rf                          (bif),
        .data_from_RF_to_chip_output (hold_word),
        .core_hold                   (core_hold),
        .stream_done                 (stream_done),
        .err_frame                   (err_frame)
    );

    always #5 clk1 = ~clk1;

    // register file with one cycle of read latency; drives zero when not read
    always @(posedge clk1)
        bif.rf_rdata <= bif.rf_re ? rd_word : 64'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {LAD2, LAD1} = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run(input logic [1:0] ph, input int n);
        {LAD2, LAD1} = ph;
        we_cnt = 0;
        re_cnt = 0;
        done_cnt = 0;
        hold_lo = 0;
        first_done = -1;
        last_done = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bif.rf_we) begin
                we_cnt++;
                we_addr = bif.rf_addr;
                we_data = bif.rf_wdata;
            end
            if (bif.rf_re) re_cnt++;
            if (!core_hold) hold_lo++;
            if (stream_done) begin
                done_cnt++;
                last_done = i;
                if (first_done < 0) first_done = i;
            end
        end
    endtask

    initial begin
        do_reset();
        chk("rst_we", 64'(bif.rf_we), 64'd0);
        chk("rst_re", 64'(bif.rf_re), 64'd0);
        chk("rst_addr", 64'(bif.rf_addr), 64'd0);
        chk("rst_wdata", bif.rf_wdata, 64'd0);
        chk("rst_hold", hold_word, 64'd0);
        chk("rst_err", 64'(err_frame), 64'd0);
        chk("rst_done", 64'(stream_done), 64'd0);
        chk("rst_core_hold", 64'(core_hold), 64'd0);

        // full write frame
        addr_reg = 10'h155;
        din_reg = 64'hDEADBEEF_01234567;
        run(2'b01, 10);
        chk("wr_hold_addr_phase", 64'(hold_lo), 64'd0);
        run(2'b10, 64);
        chk("wr_no_early_we", 64'(we_cnt), 64'd0);
        run(2'b00, 1);
        chk("wr_we_first", 64'(bif.rf_we), 64'd1);
        chk("wr_core_hold_commit", 64'(core_hold), 64'd1);
        run(2'b00, 3);
        chk("wr_we_once", 64'(we_cnt), 64'd0);
        chk("wr_addr", 64'(bif.rf_addr), 64'h155);
        chk("wr_data", bif.rf_wdata, 64'hDEADBEEF01234567);
        chk("wr_err", 64'(err_frame), 64'd0);
        chk("wr_core_hold_idle", 64'(core_hold), 64'd0);

        // short data frame
        din_reg = 64'h1111_2222_3333_4444;
        run(2'b01, 10);
        run(2'b10, 40);
        run(2'b00, 3);
        chk("short_no_we", 64'(we_cnt), 64'd0);
        chk("short_err", 64'(err_frame), 64'd1);
        run(2'b00, 5);
        chk("short_err_sticky", 64'(err_frame), 64'd1);
        chk("short_wdata_kept", bif.rf_wdata, 64'hDEADBEEF01234567);
        do_reset();
        chk("short_err_rst", 64'(err_frame), 64'd0);

        // read with full address
        addr_reg = 10'h2A0;
        rd_word = 64'hA5A5A5A5_A5A5A5A5;
        run(2'b01, 10);
        run(2'b00, 1);
        chk("rd_preload_err", 64'(err_frame), 64'd0);
        run(2'b11, 1);
        chk("rd_re_c1", 64'(bif.rf_re), 64'd1);
        chk("rd_addr", 64'(bif.rf_addr), 64'h2A0);
        chk("rd_we_c1", 64'(bif.rf_we), 64'd0);
        run(2'b11, 1);
        chk("rd_re_c2", 64'(bif.rf_re), 64'd0);
        chk("rd_hold_c2", hold_word, 64'hA5A5A5A5A5A5A5A5);
        run(2'b11, 1);
        chk("rd_hold_c3", hold_word, 64'hA5A5A5A5A5A5A5A5);
        run(2'b11, 63);
        chk("rd_no_early_done", 64'(done_cnt), 64'd0);
        run(2'b11, 1);
        chk("rd_done_c67", 64'(stream_done), 64'd1);
        run(2'b00, 2);
        chk("rd_hold_kept", hold_word, 64'hA5A5A5A5A5A5A5A5);
        chk("rd_err", 64'(err_frame), 64'd0);
        chk("rd_done_gone", 64'(done_cnt), 64'd0);

        // read without address
        do_reset();
        run(2'b11, 5);
        chk("noaddr_re", 64'(re_cnt), 64'd0);
        chk("noaddr_core_hold", 64'(hold_lo), 64'd0);
        chk("noaddr_err", 64'(err_frame), 64'd1);
        chk("noaddr_hold", hold_word, 64'd0);
        run(2'b00, 1);

        // continuous read over two frames
        do_reset();
        rd_word = 64'h0F1E2D3C_4B5A6978;
        run(2'b01, 10);
        run(2'b00, 1);
        run(2'b11, 140);
        chk("cont_done_cnt", 64'(done_cnt), 64'd2);
        chk("cont_done_first", 64'(first_done), 64'd67);
        chk("cont_done_last", 64'(last_done), 64'd134);
        chk("cont_re_once", 64'(re_cnt), 64'd1);
        chk("cont_hold", hold_word, 64'h0F1E2D3C4B5A6978);
        run(2'b00, 1);

        // reset in the middle of a data frame
        din_reg = 64'h0123_4567_89AB_CDEF;
        run(2'b01, 10);
        run(2'b10, 29);
        rst = 1'b1;
        run(2'b10, 1);
        rst = 1'b0;
        {LAD2, LAD1} = 2'b00;
        #1;
        chk("mid_we", 64'(bif.rf_we), 64'd0);
        chk("mid_re", 64'(bif.rf_re), 64'd0);
        chk("mid_addr", 64'(bif.rf_addr), 64'd0);
        chk("mid_wdata", bif.rf_wdata, 64'd0);
        chk("mid_hold", hold_word, 64'd0);
        chk("mid_err", 64'(err_frame), 64'd0);
        chk("mid_idle", 64'(core_hold), 64'd0);
        run(2'b00, 4);
        chk("mid_no_we", 64'(we_cnt), 64'd0);
        chk("mid_no_hold", 64'(64'd4 - 64'(hold_lo)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
